mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between instruction fetch and the data load/store path, so both can use one memory. Grants one requester at a time with fixed data priority and drives a registered request/response handshake to memory. Checks data-access alignment before issuing and aborts hung transactions with a watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the memory port arbiter.
// The access-size and read/write encodings match those used by decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_D
  } arb_owner_t;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Size code 3 has no meaning, so it is always reported as an error.
  function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      MEM_SIZE_B: bad = 1'b0;
      MEM_SIZE_H: bad = addr[0];
      MEM_SIZE_W: bad = (addr[1:0] != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the shared memory port.
// master is the arbiter's view; slave is the requesters and memory.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic        if_err;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_r_w;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_r_w;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        busy;

  modport master (
    input  if_req, if_addr, d_req, d_r_w, d_addr, d_wdata, d_size,
    input  m_ready, m_rvalid, m_rdata,
    output if_done, if_err, if_rdata, d_done, d_err, d_rdata,
    output m_req, m_r_w, m_addr, m_wdata, m_size, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_r_w, d_addr, d_wdata, d_size,
    output m_ready, m_rvalid, m_rdata,
    input  if_done, if_err, if_rdata, d_done, d_err, d_rdata,
    input  m_req, m_r_w, m_addr, m_wdata, m_size, busy
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Transaction watchdog: counts while enabled and flags the cycle in which
// the count would reach TIMEOUT_CYCLES. A limit of 0 never expires.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WIDTH          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   count_inc;

  assign count_inc = {1'b0, count} + (WIDTH+1)'(1);
  assign expired   = enable && (TIMEOUT_CYCLES != 0) &&
                     (count_inc == (WIDTH+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data wins ties; misaligned accesses and hung transactions complete with err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  arb_state_t  state, state_n;
  arb_owner_t  owner, owner_n;
  logic        m_req, m_req_n, m_r_w, m_r_w_n;
  logic [31:0] m_addr, m_addr_n, m_wdata, m_wdata_n;
  logic [1:0]  m_size, m_size_n;
  logic        if_done, if_done_n, if_err, if_err_n;
  logic        d_done, d_done_n, d_err, d_err_n;
  logic [31:0] if_rdata, if_rdata_n, d_rdata, d_rdata_n;
  logic        busy;
  logic        fin, fin_err, fin_load;
  logic [31:0] fin_data;
  logic        wd_clear, wd_enable, wd_expired;

  assign wd_enable = (state == ISSUE) || (state == WAIT_RD);

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WIDTH         (WD_WIDTH)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWNER_IF;
      m_req    <= 1'b0;
      m_r_w    <= MEM_READ;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_size   <= MEM_SIZE_B;
      if_done  <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      m_req    <= m_req_n;
      m_r_w    <= m_r_w_n;
      m_addr   <= m_addr_n;
      m_wdata  <= m_wdata_n;
      m_size   <= m_size_n;
      if_done  <= if_done_n;
      if_err   <= if_err_n;
      if_rdata <= if_rdata_n;
      d_done   <= d_done_n;
      d_err    <= d_err_n;
      d_rdata  <= d_rdata_n;
      busy     <= (state_n != IDLE);
    end
  end

  // Every path into RESP raises fin; the owner's done/err/rdata are routed after the case.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    m_req_n    = m_req;
    m_r_w_n    = m_r_w;
    m_addr_n   = m_addr;
    m_wdata_n  = m_wdata;
    m_size_n   = m_size;
    if_done_n  = 1'b0;
    if_err_n   = 1'b0;
    d_done_n   = 1'b0;
    d_err_n    = 1'b0;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_load   = 1'b0;
    fin_data   = '0;
    wd_clear   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.d_req) begin
          wd_clear  = 1'b1;
          owner_n   = OWNER_D;
          m_r_w_n   = bus.d_r_w;
          m_addr_n  = bus.d_addr;
          m_wdata_n = bus.d_wdata;
          m_size_n  = bus.d_size;
          if (is_misaligned(bus.d_addr, bus.d_size)) begin
            state_n = RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_n = ISSUE;
            m_req_n = 1'b1;
          end
        end else if (bus.if_req) begin
          wd_clear = 1'b1;
          owner_n  = OWNER_IF;
          m_r_w_n  = MEM_READ;
          m_addr_n = bus.if_addr;
          m_size_n = MEM_SIZE_W;
          if (is_misaligned(bus.if_addr, MEM_SIZE_W)) begin
            state_n = RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_n = ISSUE;
            m_req_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          m_req_n = 1'b0;
          if (m_r_w == MEM_WRITE) begin
            state_n = RESP;
            fin     = 1'b1;
          end else if (bus.m_rvalid) begin
            state_n  = RESP;
            fin      = 1'b1;
            fin_load = 1'b1;
            fin_data = bus.m_rdata;
          end else begin
            state_n = WAIT_RD;
          end
        end else if (wd_expired) begin
          m_req_n  = 1'b0;
          state_n  = RESP;
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_load = 1'b1;
        end
      end
      WAIT_RD: begin
        if (bus.m_rvalid) begin
          state_n  = RESP;
          fin      = 1'b1;
          fin_load = 1'b1;
          fin_data = bus.m_rdata;
        end else if (wd_expired) begin
          state_n  = RESP;
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_load = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        m_req_n = 1'b0;
      end
    endcase

    if (fin) begin
      if (owner_n == OWNER_D) begin
        d_done_n = 1'b1;
        d_err_n  = fin_err;
        if (fin_load) d_rdata_n = fin_data;
      end else begin
        if_done_n = 1'b1;
        if_err_n  = fin_err;
        if (fin_load) if_rdata_n = fin_data;
      end
    end
  end

  assign bus.m_req    = m_req;
  assign bus.m_r_w    = m_r_w;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.m_size   = m_size;
  assign bus.if_done  = if_done;
  assign bus.if_err   = if_err;
  assign bus.if_rdata = if_rdata;
  assign bus.d_done   = d_done;
  assign bus.d_err    = d_err;
  assign bus.d_rdata  = d_rdata;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, watchdog limit set to 4.
// Each cycle starts 1 time unit after the rising edge: outputs are checked, then inputs driven.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clock;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;

  logic [31:0] mis_addr [4] = '{32'h0000_0202, 32'h0000_0201, 32'h0000_0300, 32'h0000_0203};
  logic [1:0]  mis_size [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
  logic        mis_err  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                               input logic d_req, input logic d_r_w,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata,
                               input logic [1:0] d_size);
    bus.if_req  = if_req;
    bus.if_addr = if_addr;
    bus.d_req   = d_req;
    bus.d_r_w   = d_r_w;
    bus.d_addr  = d_addr;
    bus.d_wdata = d_wdata;
    bus.d_size  = d_size;
  endtask

  task automatic driveMemory(input logic ready, input logic rvalid, input logic [31:0] rdata);
    bus.m_ready  = ready;
    bus.m_rvalid = rvalid;
    bus.m_rdata  = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    driveMemory(0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("rst_m_req", bus.m_req, 0);
    checkOutput("rst_m_r_w", bus.m_r_w, 1);
    checkOutput("rst_m_addr", bus.m_addr, 0);
    checkOutput("rst_m_size", bus.m_size, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_if_done", bus.if_done, 0);
    checkOutput("rst_d_rdata", bus.d_rdata, 0);
    reset = 1'b0;
    nextCycle();

    $display("[TB] fetch read with separate ready and rvalid");
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("fr_m_req", bus.m_req, 1);
    checkOutput("fr_m_addr", bus.m_addr, 32'h100);
    checkOutput("fr_m_size", bus.m_size, 2);
    checkOutput("fr_m_r_w", bus.m_r_w, 1);
    checkOutput("fr_busy", bus.busy, 1);
    driveMemory(1, 0, 0);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("fr_wait_m_req", bus.m_req, 0);
    nextCycle();
    checkOutput("fr_wait_done", bus.if_done, 0);
    driveMemory(0, 1, 32'hDEADBEEF);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("fr_done", bus.if_done, 1);
    checkOutput("fr_rdata", bus.if_rdata, 32'hDEADBEEF);
    checkOutput("fr_err", bus.if_err, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("fr_done_pulse", bus.if_done, 0);
    checkOutput("fr_idle_busy", bus.busy, 0);

    $display("[TB] simultaneous store and fetch");
    applyStimulus(1, 32'h104, 1, MEM_WRITE, 32'h200, 32'h12345678, 2);
    nextCycle();
    checkOutput("sim_m_req", bus.m_req, 1);
    checkOutput("sim_m_r_w", bus.m_r_w, 0);
    checkOutput("sim_m_addr", bus.m_addr, 32'h200);
    checkOutput("sim_m_wdata", bus.m_wdata, 32'h12345678);
    driveMemory(1, 0, 0);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("sim_d_done", bus.d_done, 1);
    checkOutput("sim_d_err", bus.d_err, 0);
    checkOutput("sim_if_done", bus.if_done, 0);
    checkOutput("sim_resp_m_req", bus.m_req, 0);
    applyStimulus(1, 32'h104, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("sim_idle_m_req", bus.m_req, 0);
    nextCycle();
    checkOutput("sim_fetch_m_req", bus.m_req, 1);
    checkOutput("sim_fetch_m_addr", bus.m_addr, 32'h104);
    checkOutput("sim_fetch_m_r_w", bus.m_r_w, 1);
    driveMemory(1, 1, 32'hCAFEF00D);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("same_cycle_done", bus.if_done, 1);
    checkOutput("same_cycle_rdata", bus.if_rdata, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("same_cycle_pulse", bus.if_done, 0);

    $display("[TB] data alignment vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, MEM_WRITE, mis_addr[i], 32'hA5A5A5A5, mis_size[i]);
      nextCycle();
      if (mis_err[i]) begin
        checkOutput($sformatf("mis%0d_done", i), bus.d_done, 1);
        checkOutput($sformatf("mis%0d_err", i), bus.d_err, 1);
        checkOutput($sformatf("mis%0d_m_req", i), bus.m_req, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput($sformatf("mis%0d_pulse", i), bus.d_done, 0);
        checkOutput($sformatf("mis%0d_m_req_after", i), bus.m_req, 0);
      end else begin
        checkOutput($sformatf("mis%0d_m_req", i), bus.m_req, 1);
        checkOutput($sformatf("mis%0d_m_size", i), bus.m_size, 0);
        checkOutput($sformatf("mis%0d_m_addr", i), bus.m_addr, 32'h203);
        driveMemory(1, 0, 0);
        nextCycle();
        driveMemory(0, 0, 0);
        checkOutput($sformatf("mis%0d_done", i), bus.d_done, 1);
        checkOutput($sformatf("mis%0d_err", i), bus.d_err, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
      end
    end

    $display("[TB] misaligned fetch");
    applyStimulus(1, 32'h102, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("mis_if_done", bus.if_done, 1);
    checkOutput("mis_if_err", bus.if_err, 1);
    checkOutput("mis_if_m_req", bus.m_req, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    $display("[TB] data load, then watchdog timeout");
    applyStimulus(0, 0, 1, MEM_READ, 32'h500, 0, 2);
    nextCycle();
    driveMemory(1, 1, 32'h55AA55AA);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("dl_done", bus.d_done, 1);
    checkOutput("dl_rdata", bus.d_rdata, 32'h55AA55AA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, MEM_READ, 32'h400, 0, 2);
    nextCycle();
    checkOutput("wd_m_req_c1", bus.m_req, 1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("wd_m_req_c4", bus.m_req, 1);
    checkOutput("wd_no_done_c4", bus.d_done, 0);
    nextCycle();
    checkOutput("wd_m_req_drop", bus.m_req, 0);
    checkOutput("wd_done", bus.d_done, 1);
    checkOutput("wd_err", bus.d_err, 1);
    checkOutput("wd_rdata", bus.d_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    driveMemory(0, 1, 32'h77777777);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("stray_d_done", bus.d_done, 0);
    checkOutput("stray_if_done", bus.if_done, 0);
    checkOutput("stray_d_rdata", bus.d_rdata, 0);
    checkOutput("stray_busy", bus.busy, 0);

    $display("[TB] reset during WAIT_RD");
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0);
    nextCycle();
    driveMemory(1, 0, 0);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("rr_wait_busy", bus.busy, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_m_req", bus.m_req, 0);
    checkOutput("rr_busy", bus.busy, 0);
    checkOutput("rr_done", bus.if_done, 0);
    checkOutput("rr_rdata", bus.if_rdata, 0);
    driveMemory(0, 1, 32'h99999999);
    nextCycle();
    driveMemory(0, 0, 0);
    checkOutput("rr_late_done", bus.if_done, 0);
    checkOutput("rr_late_rdata", bus.if_rdata, 0);
    nextCycle();
    checkOutput("rr_late_done2", bus.if_done, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
